// File: rtl/nem_ohmux_sel_sequencer.sv
// Break-before-make one-hot select sequencer for NEM-relay inverting muxes.
// Optional build macro NEM_SEL_SKIP_SAME_EN: a repeat of the current selection, or a re-park, completes in one cycle.
module nem_ohmux_sel_sequencer #(
  parameter int N_IN    = 2,
  parameter int SEL_W   = 1,
  parameter int T_BREAK = 4,
  parameter int T_MAKE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic [N_IN-1:0]  sel_oh,
  output logic             settled,
  output logic             done,
  output logic [SEL_W-1:0] cur_sel
);

  localparam int T_MAX = (T_BREAK > T_MAKE) ? T_BREAK : T_MAKE;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [N_IN-1:0] ONE_HOT0 = N_IN'(1);

  typedef enum logic [1:0] {IDLE, BREAK, MAKE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             park_q, park_d;
  logic [N_IN-1:0]  sel_oh_d;
  logic             settled_d, done_d;
  logic [SEL_W-1:0] cur_sel_d;
  logic             accept, req_park, skip;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_park  = ({1'b0, req_sel} >= (SEL_W+1)'(N_IN));

`ifdef NEM_SEL_SKIP_SAME_EN
  assign skip = (!req_park && settled && (req_sel == cur_sel)) ||
                (req_park && !settled && (sel_oh == '0));
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      park_q  <= 1'b0;
      sel_oh  <= '0;
      settled <= 1'b0;
      done    <= 1'b0;
      cur_sel <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      park_q  <= park_d;
      sel_oh  <= sel_oh_d;
      settled <= settled_d;
      done    <= done_d;
      cur_sel <= cur_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    park_d    = park_q;
    sel_oh_d  = sel_oh;
    settled_d = settled;
    done_d    = 1'b0;
    cur_sel_d = cur_sel;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (skip) begin
            done_d = 1'b1;
          end else begin
            // Open every relay before any new path may close.
            state_d   = BREAK;
            cnt_d     = CNT_W'(T_BREAK - 1);
            sel_d     = req_sel;
            park_d    = req_park;
            sel_oh_d  = '0;
            settled_d = 1'b0;
          end
        end
      end
      BREAK: begin
        if (cnt_q == '0) begin
          if (park_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = MAKE;
            cnt_d    = CNT_W'(T_MAKE - 1);
            sel_oh_d = ONE_HOT0 << sel_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MAKE: begin
        if (cnt_q == '0) begin
          state_d   = IDLE;
          settled_d = 1'b1;
          cur_sel_d = sel_q;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nem_ohmux_sel_sequencer.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run against a timeline model.
module tb_nem_ohmux_sel_sequencer;
  localparam int TB1 = 3, TM1 = 5, TB2 = 2, TM2 = 3;
`ifdef NEM_SEL_SKIP_SAME_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic v1 = 1'b0; logic [0:0] s1 = '0; logic rdy1, st1, d1; logic [1:0] oh1; logic [0:0] cur1;
  logic v2 = 1'b0; logic [1:0] s2 = '0; logic rdy2, st2, d2; logic [2:0] oh2; logic [1:0] cur2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  nem_ohmux_sel_sequencer #(.N_IN(2), .SEL_W(1), .T_BREAK(TB1), .T_MAKE(TM1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(v1), .req_sel(s1), .req_ready(rdy1),
    .sel_oh(oh1), .settled(st1), .done(d1), .cur_sel(cur1));

  nem_ohmux_sel_sequencer #(.N_IN(3), .SEL_W(2), .T_BREAK(TB2), .T_MAKE(TM2)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_sel(s2), .req_ready(rdy2),
    .sel_oh(oh2), .settled(st2), .done(d2), .cur_sel(cur2));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input bit which, input int lim);
    for (int k = 0; k < lim; k++) begin
      step_edge();
      if ((which == 1'b0) ? d1 : d2) break;
    end
    chk(name, int'((which == 1'b0) ? d1 : d2), 1);
  endtask

  typedef struct { int r; int v; int s; int oh; int st; int d; int rdy; int cc; int cur; } vec_t;
  vec_t tbl[29];

  function automatic vec_t mkv(int r, int v, int s, int oh, int st, int d, int rdy, int cc, int cur);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.oh = oh; t.st = st; t.d = d; t.rdy = rdy; t.cc = cc; t.cur = cur;
    return t;
  endfunction

  // Reference model: expected outputs from edges elapsed since acceptance.
  typedef struct { bit busy; int acc; int s; bit park; int oh; bit st; int cur; bit d; } m_t;

  function automatic m_t mstep(m_t m, bit r, bit v, int rs, int nin, int tb, int tm, int n);
    m_t q;
    q = m;
    q.d = 1'b0;
    if (r) begin
      q = '{default: 0};
    end else if (m.busy) begin
      int k;
      k = n - m.acc;
      if (k == tb) begin
        if (m.park) begin q.busy = 1'b0; q.d = 1'b1; end
        else q.oh = 1 << m.s;
      end
      if (!m.park && k == tb + tm) begin
        q.busy = 1'b0; q.st = 1'b1; q.cur = m.s; q.d = 1'b1;
      end
    end else if (v) begin
      bit pk;
      pk = (rs >= nin);
      if (SKIP && ((!pk && m.st && rs == m.cur) || (pk && !m.st && m.oh == 0))) begin
        q.d = 1'b1;
      end else begin
        q.busy = 1'b1; q.acc = n; q.s = rs; q.park = pk; q.oh = 0; q.st = 1'b0;
      end
    end
    return q;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_t m1, m2;
    int n, lnz1, zr1, lnz2, zr2;

    //          r  v  s  oh st d rdy cc cur
    tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[1]  = mkv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[3]  = mkv(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[7]  = mkv(0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[10] = mkv(0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[11] = mkv(0, 0, 0, 2, 1, 1, 1, 1, 1);
    tbl[12] = mkv(0, 0, 0, 2, 1, 0, 1, 1, 1);
    tbl[13] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[17] = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[18] = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[19] = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[20] = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[21] = mkv(0, 0, 0, 1, 1, 1, 1, 1, 0);
    tbl[22] = mkv(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[23] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[24] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[25] = mkv(0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[26] = mkv(0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[27] = mkv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[28] = mkv(0, 0, 0, 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 29; i++) begin
      rst = tbl[i].r[0];
      v1  = tbl[i].v[0];
      s1  = tbl[i].s[0:0];
      step_edge();
      chk($sformatf("vec%0d.sel_oh", i), int'(oh1), tbl[i].oh);
      chk($sformatf("vec%0d.settled", i), int'(st1), tbl[i].st);
      chk($sformatf("vec%0d.done", i), int'(d1), tbl[i].d);
      chk($sformatf("vec%0d.req_ready", i), int'(rdy1), tbl[i].rdy);
      if (tbl[i].cc != 0) chk($sformatf("vec%0d.cur_sel", i), int'(cur1), tbl[i].cur);
    end
    v1 = 1'b0;

    // Repeat of the current selection.
    v1 = 1'b1; s1 = 1'b1; step_edge(); v1 = 1'b0;
    wait_done("rep.first_done", 1'b0, 20);
    v1 = 1'b1; s1 = 1'b1; step_edge(); v1 = 1'b0;
    if (SKIP) begin
      chk("rep.skip_done", int'(d1), 1);
      chk("rep.skip_oh", int'(oh1), 2);
      chk("rep.skip_settled", int'(st1), 1);
      chk("rep.skip_ready", int'(rdy1), 1);
    end else begin
      chk("rep.break0_oh", int'(oh1), 0);
      chk("rep.break0_settled", int'(st1), 0);
      for (int k = 1; k < TB1; k++) begin step_edge(); chk($sformatf("rep.break%0d_oh", k), int'(oh1), 0); end
      step_edge(); chk("rep.make_oh", int'(oh1), 2);
      for (int k = 1; k < TM1; k++) begin step_edge(); chk($sformatf("rep.make%0d_settled", k), int'(st1), 0); end
      step_edge();
      chk("rep.settled", int'(st1), 1);
      chk("rep.done", int'(d1), 1);
      chk("rep.cur_sel", int'(cur1), 1);
    end

    // Park requests on the 3-input instance.
    rst = 1'b1; step_edge(); rst = 1'b0;
    v2 = 1'b1; s2 = 2'd3; step_edge(); v2 = 1'b0;
    if (SKIP) begin
      chk("park0.done", int'(d2), 1);
      chk("park0.ready", int'(rdy2), 1);
    end else begin
      chk("park0.ready_e0", int'(rdy2), 0);
      step_edge(); chk("park0.done_e1", int'(d2), 0);
      step_edge();
      chk("park0.done_e2", int'(d2), 1);
      chk("park0.ready_e2", int'(rdy2), 1);
      chk("park0.settled_e2", int'(st2), 0);
    end
    chk("park0.oh", int'(oh2), 0);
    v2 = 1'b1; s2 = 2'd2; step_edge(); v2 = 1'b0;
    wait_done("sel2.done", 1'b1, 20);
    chk("sel2.oh", int'(oh2), 4);
    chk("sel2.cur", int'(cur2), 2);
    v2 = 1'b1; s2 = 2'd3; step_edge(); v2 = 1'b0;
    chk("park1.oh_e0", int'(oh2), 0);
    chk("park1.settled_e0", int'(st2), 0);
    step_edge(); chk("park1.ready_e1", int'(rdy2), 0);
    step_edge();
    chk("park1.done_e2", int'(d2), 1);
    chk("park1.oh_e2", int'(oh2), 0);
    chk("park1.ready_e2", int'(rdy2), 1);

    // Randomized run against the model, plus relay-safety invariants.
    m1 = '{default: 0}; m2 = '{default: 0};
    n = 0; lnz1 = 0; zr1 = 0; lnz2 = 0; zr2 = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(63) == 0);
      v1  = ($urandom_range(2) != 0);
      s1  = 1'($urandom_range(1));
      v2  = ($urandom_range(2) != 0);
      s2  = 2'($urandom_range(3));
      @(posedge clk);
      n++;
      m1 = mstep(m1, rst, v1, int'(s1), 2, TB1, TM1, n);
      m2 = mstep(m2, rst, v2, int'(s2), 3, TB2, TM2, n);
      #1;
      chk("rnd.oh1", int'(oh1), m1.oh);
      chk("rnd.st1", int'(st1), int'(m1.st));
      chk("rnd.done1", int'(d1), int'(m1.d));
      chk("rnd.rdy1", int'(rdy1), int'(!m1.busy));
      if (m1.st) chk("rnd.cur1", int'(cur1), m1.cur);
      chk("rnd.oh2", int'(oh2), m2.oh);
      chk("rnd.st2", int'(st2), int'(m2.st));
      chk("rnd.done2", int'(d2), int'(m2.d));
      chk("rnd.rdy2", int'(rdy2), int'(!m2.busy));
      if (m2.st) chk("rnd.cur2", int'(cur2), m2.cur);
      chk("rnd.onehot1", int'($countones(oh1) <= 1), 1);
      chk("rnd.onehot2", int'($countones(oh2) <= 1), 1);
      if (oh1 != 0) begin
        if (lnz1 != 0 && int'(oh1) != lnz1) chk("rnd.gap1", int'(zr1 >= TB1), 1);
        lnz1 = int'(oh1); zr1 = 0;
      end else zr1++;
      if (oh2 != 0) begin
        if (lnz2 != 0 && int'(oh2) != lnz2) chk("rnd.gap2", int'(zr2 >= TB2), 1);
        lnz2 = int'(oh2); zr2 = 0;
      end else zr2++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
